// File: rtl/sdiv_seq_ctrl.sv
// Sequential signed 64/32 divide controller around an unsigned combinational array divider core.
// Optional floor-division rounding is compiled in when SDIV_FLOOR_EN is defined.
module sdiv_seq_ctrl #(
    parameter int SETTLE_CYCLES = 34
) (
    input  logic        clk,
    input  logic        reset,
    // valid/ready: a transfer happens on a rising edge where valid && ready are both high;
    // the sender holds its data stable while valid is high and ready is low.
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] dividend,
    input  logic [31:0] divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] q,
    output logic [31:0] remainder,
    output logic        div_by_zero,
    output logic        overflow,
    output logic [63:0] div_dividend,
    output logic [31:0] div_divisor,
    input  logic [31:0] div_q,
    input  logic [31:0] div_rem,
    output logic [2:0]  dbg_state
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PREP   = 3'd1,
        S_SETTLE = 3'd2,
        S_FIX    = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [63:0]   dvd_raw_q, dvd_raw_d;
    logic [31:0]   dvs_raw_q, dvs_raw_d;
    logic          sq_q, sq_d;
    logic          sr_q, sr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0]   dd_q, dd_d;
    logic [31:0]   ds_q, ds_d;
    logic [31:0]   q_q, q_d;
    logic [31:0]   rem_q, rem_d;
    logic          dbz_q, dbz_d;
    logic          ovf_q, ovf_d;

    logic [63:0]   abs_dvd;
    logic [31:0]   abs_dvs;
    logic [31:0]   q_signed;
    logic [31:0]   r_signed;
    logic          range_ovf;

    // Magnitudes; the most negative values map onto their unsigned 2^63 / 2^31 patterns.
    assign abs_dvd   = dvd_raw_q[63] ? (64'd0 - dvd_raw_q) : dvd_raw_q;
    assign abs_dvs   = dvs_raw_q[31] ? (32'd0 - dvs_raw_q) : dvs_raw_q;
    assign q_signed  = sq_q ? (32'd0 - div_q) : div_q;
    assign r_signed  = sr_q ? (32'd0 - div_rem) : div_rem;
    assign range_ovf = sq_q ? (div_q > 32'h8000_0000) : div_q[31];

    always_comb begin
        state_d   = state_q;
        dvd_raw_d = dvd_raw_q;
        dvs_raw_d = dvs_raw_q;
        sq_d      = sq_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        dd_d      = dd_q;
        ds_d      = ds_q;
        q_d       = q_q;
        rem_d     = rem_q;
        dbz_d     = dbz_q;
        ovf_d     = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    dvd_raw_d = dividend;
                    dvs_raw_d = divisor;
                    state_d   = S_PREP;
                end
            end
            S_PREP: begin
                dd_d = abs_dvd;
                ds_d = abs_dvs;
                sq_d = dvd_raw_q[63] ^ dvs_raw_q[31];
                sr_d = dvd_raw_q[63];
                if (dvs_raw_q == 32'd0) begin
                    dbz_d   = 1'b1;
                    ovf_d   = 1'b0;
                    q_d     = 32'hFFFF_FFFF;
                    rem_d   = dvd_raw_q[31:0];
                    state_d = S_HOLD;
                end else if (abs_dvd[63:32] >= abs_dvs) begin
                    // The unsigned core quotient itself would not fit in 32 bits.
                    dbz_d   = 1'b0;
                    ovf_d   = 1'b1;
                    q_d     = 32'h8000_0000;
                    rem_d   = 32'd0;
                    state_d = S_HOLD;
                end else begin
                    cnt_d   = CW'(SETTLE_CYCLES - 1);
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_FIX: begin
                dbz_d   = 1'b0;
                state_d = S_HOLD;
                if (range_ovf) begin
                    ovf_d = 1'b1;
                    q_d   = 32'h8000_0000;
                    rem_d = 32'd0;
                end else begin
                    ovf_d = 1'b0;
                    q_d   = q_signed;
                    rem_d = r_signed;
`ifdef SDIV_FLOOR_EN
                    // Floor rounding: pull the quotient down when the remainder's sign
                    // disagrees with the divisor's sign.
                    if ((r_signed != 32'd0) && (r_signed[31] != dvs_raw_q[31])) begin
                        if (q_signed == 32'h8000_0000) begin
                            ovf_d = 1'b1;
                            q_d   = 32'h8000_0000;
                            rem_d = 32'd0;
                        end else begin
                            q_d   = q_signed - 32'd1;
                            rem_d = r_signed + dvs_raw_q;
                        end
                    end
`endif
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            dvd_raw_q <= 64'd0;
            dvs_raw_q <= 32'd0;
            sq_q      <= 1'b0;
            sr_q      <= 1'b0;
            cnt_q     <= '0;
            dd_q      <= 64'd0;
            ds_q      <= 32'd0;
            q_q       <= 32'd0;
            rem_q     <= 32'd0;
            dbz_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dvd_raw_q <= dvd_raw_d;
            dvs_raw_q <= dvs_raw_d;
            sq_q      <= sq_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            dd_q      <= dd_d;
            ds_q      <= ds_d;
            q_q       <= q_d;
            rem_q     <= rem_d;
            dbz_q     <= dbz_d;
            ovf_q     <= ovf_d;
        end
    end

    assign in_ready     = (state_q == S_IDLE) && !reset;
    assign out_valid    = (state_q == S_HOLD);
    assign q            = q_q;
    assign remainder    = rem_q;
    assign div_by_zero  = dbz_q;
    assign overflow     = ovf_q;
    assign div_dividend = dd_q;
    assign div_divisor  = ds_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_sdiv_seq_ctrl.sv
// Directed, table-driven bench for sdiv_seq_ctrl with a behavioural unsigned divider core.
// Expected values follow truncating division unless SDIV_FLOOR_EN is defined.
module tb_sdiv_seq_ctrl;

    localparam int SC = 34;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] dividend;
    logic [31:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] q;
    logic [31:0] remainder;
    logic        div_by_zero;
    logic        overflow;
    logic [63:0] div_dividend;
    logic [31:0] div_divisor;
    logic [31:0] div_q;
    logic [31:0] div_rem;
    logic [2:0]  dbg_state;

    int checks;
    int failures;
    logic [65:0] exp_q[$];

    typedef struct {
        logic [63:0] dvd;
        logic [31:0] dvs;
        logic [31:0] e_q;
        logic [31:0] e_rem;
        logic        e_dbz;
        logic        e_ovf;
        int          e_cycle;
    } vec_t;

    vec_t vecs[10];

    sdiv_seq_ctrl #(.SETTLE_CYCLES(SC)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid), .out_ready(out_ready),
        .q(q), .remainder(remainder),
        .div_by_zero(div_by_zero), .overflow(overflow),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_q(div_q), .div_rem(div_rem),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural unsigned core
    logic [63:0] core_quo;
    logic [63:0] core_mod;
    always_comb begin
        core_quo = 64'd0;
        core_mod = 64'd0;
        if (div_divisor != 32'd0) begin
            core_quo = div_dividend / {32'd0, div_divisor};
            core_mod = div_dividend % {32'd0, div_divisor};
        end
        div_q   = core_quo[31:0];
        div_rem = core_mod[31:0];
    end

    function automatic logic [63:0] abs64(input logic [63:0] v);
        return v[63] ? (64'd0 - v) : v;
    endfunction

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, " out_valid"}, 64'(out_valid), 64'd0);
        chk({nm, " q"}, 64'(q), 64'd0);
        chk({nm, " remainder"}, 64'(remainder), 64'd0);
        chk({nm, " flags"}, 64'({div_by_zero, overflow}), 64'd0);
        chk({nm, " div_dividend"}, div_dividend, 64'd0);
        chk({nm, " div_divisor"}, 64'(div_divisor), 64'd0);
    endtask

    // driver: issue one operation, measure latency, compare against the scoreboard
    task automatic run_op(input vec_t v, input string nm);
        int          lat;
        bit          seen;
        logic [65:0] e;
        exp_q.push_back({v.e_dbz, v.e_ovf, v.e_q, v.e_rem});
        @(negedge clk);
        for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
        chk({nm, " in_ready before issue"}, 64'(in_ready), 64'd1);
        dividend = v.dvd;
        divisor  = v.dvs;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 5 && v.e_cycle > 2) begin
                chk({nm, " settle div_dividend"}, div_dividend, abs64(v.dvd));
                chk({nm, " settle div_divisor"}, 64'(div_divisor), 64'(abs32(v.dvs)));
                chk({nm, " settle in_ready"}, 64'(in_ready), 64'd0);
            end
            if (out_valid) seen = 1'b1;
        end
        chk({nm, " out_valid seen"}, 64'(seen), 64'd1);
        chk({nm, " out_valid cycle"}, 64'(lat + 1), 64'(v.e_cycle));
        e = exp_q.pop_front();
        chk({nm, " q"}, 64'(q), 64'(e[63:32]));
        chk({nm, " remainder"}, 64'(remainder), 64'(e[31:0]));
        chk({nm, " div_by_zero"}, 64'(div_by_zero), 64'(e[65]));
        chk({nm, " overflow"}, 64'(overflow), 64'(e[64]));
        if (out_ready) begin
            @(posedge clk);
            #1;
            chk({nm, " out_valid after accept"}, 64'(out_valid), 64'd0);
            chk({nm, " in_ready after accept"}, 64'(in_ready), 64'd1);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = 64'd0;
        divisor   = 32'd0;

        vecs[0] = '{64'd4, 32'd2, 32'd2, 32'd0, 1'b0, 1'b0, SC + 3};
`ifdef SDIV_FLOOR_EN
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFF8, 32'd3, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0, SC + 3};
        vecs[6] = '{64'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF1, 32'hFFFF_FFFB, 1'b0, 1'b0, SC + 3};
`else
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFF8, 32'd3, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b0, 1'b0, SC + 3};
        vecs[6] = '{64'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0, 1'b0, SC + 3};
`endif
        vecs[2] = '{64'h1234_5678_9ABC_DEF0, 32'd0, 32'hFFFF_FFFF, 32'h9ABC_DEF0, 1'b1, 1'b0, 2};
        vecs[3] = '{64'h1_0000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 2};
        vecs[4] = '{64'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0, 1'b1, SC + 3};
        vecs[5] = '{64'hFFFF_FFFF_8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0, 1'b0, SC + 3};
        vecs[7] = '{64'h8000_0000_0000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 2};
        vecs[8] = '{64'd7, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, SC + 3};
        vecs[9] = '{64'hFFFF_FFFF_FFFF_FFFF, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, SC + 3};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", 64'(in_ready), 64'd0);
        chk_idle_outputs("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post-reset in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // backpressure: result held while out_ready is low, new requests ignored
        begin
            vec_t hv;
            hv = '{64'd50, 32'd5, 32'd10, 32'd0, 1'b0, 1'b0, SC + 3};
            out_ready = 1'b0;
            run_op(hv, "hold");
            dividend = 64'd999;
            divisor  = 32'd1;
            in_valid = 1'b1;
            for (int c = 0; c < 5; c++) begin
                @(posedge clk);
                #1;
                chk($sformatf("hold%0d out_valid", c), 64'(out_valid), 64'd1);
                chk($sformatf("hold%0d q", c), 64'(q), 64'd10);
                chk($sformatf("hold%0d remainder", c), 64'(remainder), 64'd0);
                chk($sformatf("hold%0d flags", c), 64'({div_by_zero, overflow}), 64'd0);
                chk($sformatf("hold%0d in_ready", c), 64'(in_ready), 64'd0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            chk("hold release out_valid", 64'(out_valid), 64'd0);
            chk("hold release in_ready", 64'(in_ready), 64'd1);
        end

        // reset in the middle of SETTLE discards the operation
        @(negedge clk);
        dividend = 64'd1000;
        divisor  = 32'd3;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("midsettle div_dividend", div_dividend, 64'd1000);
        reset = 1'b1;
        #1;
        chk("midsettle in_ready during reset", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk_idle_outputs("midsettle reset");
        chk("midsettle in_ready after reset", 64'(in_ready), 64'd1);
        begin
            bit stray;
            stray = 1'b0;
            for (int c = 0; c < SC + 5; c++) begin
                @(posedge clk);
                #1;
                if (out_valid) stray = 1'b1;
            end
            chk("midsettle no stray out_valid", 64'(stray), 64'd0);
        end
        run_op(vecs[6], "after reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
